gcm_aes_128: RTL and testbench



---
 rtl/gcm_aes_128.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_gcm_aes_128.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_aes_128.sv
// AES-128 GCM authenticated-encryption engine: GHASH with a single-cycle GF(2^128)
// multiplier around an iterative AES-128 core (start to done = 11 cycles).

module aes128_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout,
    output logic         done
);
    logic [127:0] st, rk, rk_next;
    logic [3:0]   round;
    logic         busy;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] aa, p;
        aa = a;
        p  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as affine(x^254): multiplicative inverse by square-and-multiply.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gmul8(p, p);
            r = gmul8(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b  [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int unsigned i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                sr[4*c+r] = b[4*((c+r)%4)+r];
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
            if (last)
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            else
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o ^ k;
    endfunction

    always_comb rk_next = next_key(rk, rcon(round));

    // Rounds 1..10 run on the ten edges after start; the eleventh edge registers the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= '0;
            rk    <= '0;
            round <= '0;
            busy  <= 1'b0;
            dout  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                st    <= din ^ key;
                rk    <= key;
                round <= 4'd1;
                busy  <= 1'b1;
            end else if (busy) begin
                if (round == 4'd11) begin
                    dout <= st;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    st    <= aes_round(st, rk_next, round == 4'd10);
                    rk    <= rk_next;
                    round <= round + 4'd1;
                end
            end
        end
    end
endmodule

module gcm_aes_128 (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_new_instance,
    input  logic         i_pt_instance,
    input  logic [0:127] i_cipher_key,
    input  logic [0:95]  i_iv,
    input  logic [0:127] i_plain_text,
    input  logic [0:127] i_aad,
    input  logic [0:63]  i_plain_text_size,
    input  logic [0:63]  i_aad_size,
    output logic [0:127] o_cipher_text,
    output logic [0:127] o_tag,
    output logic         o_tag_ready,
    output logic         o_cp_ready
);
    typedef enum logic [2:0] {IDLE, HGEN, J0ENC, WAIT_DATA, CTENC, LENBLK, DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_r, h_r, ej0_r, cb_r, s_r, pt_r;
    logic [95:0]  iv_r;
    logic [63:0]  aad_bits, pt_bits;
    logic [57:0]  aad_left, pt_left;
    logic [127:0] pt_in, aad_in, aad_mask, pt_mask, ct_val, ghash_in, s_next;
    logic [127:0] core_key, core_din, core_dout;
    logic         core_start, core_done, take_aad, take_pt;

    function automatic logic [57:0] n_blocks(input logic [63:0] bits);
        return {1'b0, bits[63:7]} + {57'd0, |bits[6:0]};
    endfunction

    function automatic logic [127:0] tail_mask(input logic [6:0] r);
        if (r == 7'd0) return '1;
        return ~({128{1'b1}} >> r);
    endfunction

    // GCM bit order: the MSB of the vector is the x^0 coefficient.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int unsigned i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
        end
        return z;
    endfunction

    aes128_core u_aes (
        .clk   (clk),
        .rst_n (i_rst_n),
        .start (core_start),
        .key   (core_key),
        .din   (core_din),
        .dout  (core_dout),
        .done  (core_done)
    );

    always_comb begin
        pt_in    = i_plain_text;
        aad_in   = i_aad;
        aad_mask = (aad_left == 58'd1) ? tail_mask(aad_bits[6:0]) : '1;
        pt_mask  = (pt_left == 58'd1) ? tail_mask(pt_bits[6:0]) : '1;
        ct_val   = (pt_r ^ core_dout) & pt_mask;
        take_aad = (state_q == WAIT_DATA) && i_pt_instance && (aad_left != '0);
        take_pt  = (state_q == WAIT_DATA) && i_pt_instance && (aad_left == '0) && (pt_left != '0);
        ghash_in = s_r;
        case (state_q)
            WAIT_DATA: ghash_in = s_r ^ (aad_in & aad_mask);
            CTENC:     ghash_in = s_r ^ ct_val;
            LENBLK:    ghash_in = s_r ^ {aad_bits, pt_bits};
            default:   ghash_in = s_r;
        endcase
        s_next = gf_mul(ghash_in, h_r);
    end

    // H generation starts on the strobe edge itself, so the core takes the unlatched key.
    always_comb begin
        core_start = 1'b0;
        core_key   = key_r;
        core_din   = cb_r;
        if (i_new_instance) begin
            core_start = 1'b1;
            core_key   = i_cipher_key;
            core_din   = '0;
        end else if (state_q == HGEN && core_done) begin
            core_start = 1'b1;
            core_din   = {iv_r, 31'd0, 1'b1};
        end else if (take_pt) begin
            core_start = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HGEN:      if (core_done) state_d = J0ENC;
            J0ENC:     if (core_done)
                           state_d = (aad_left == '0 && pt_left == '0) ? LENBLK : WAIT_DATA;
            WAIT_DATA: if (aad_left == '0 && pt_left == '0)
                           state_d = LENBLK;
                       else if (take_aad && aad_left == 58'd1 && pt_left == '0)
                           state_d = LENBLK;
                       else if (take_pt)
                           state_d = CTENC;
            CTENC:     if (core_done) state_d = (pt_left == 58'd1) ? LENBLK : WAIT_DATA;
            LENBLK:    state_d = DONE;
            default:   state_d = state_q;
        endcase
        if (i_new_instance) state_d = HGEN;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_r <= '0; iv_r <= '0; h_r <= '0; ej0_r <= '0; cb_r <= '0;
            s_r <= '0; pt_r <= '0; aad_bits <= '0; pt_bits <= '0;
            aad_left <= '0; pt_left <= '0;
            o_cipher_text <= '0; o_tag <= '0; o_tag_ready <= 1'b0; o_cp_ready <= 1'b0;
        end else begin
            o_cp_ready <= 1'b0;
            if (i_new_instance) begin
                key_r       <= i_cipher_key;
                iv_r        <= i_iv;
                aad_bits    <= i_aad_size;
                pt_bits     <= i_plain_text_size;
                aad_left    <= n_blocks(i_aad_size);
                pt_left     <= n_blocks(i_plain_text_size);
                s_r         <= '0;
                o_tag       <= '0;
                o_tag_ready <= 1'b0;
            end else begin
                case (state_q)
                    HGEN:  if (core_done) h_r <= core_dout;
                    J0ENC: if (core_done) begin
                        ej0_r <= core_dout;
                        cb_r  <= {iv_r, 32'd2};
                    end
                    WAIT_DATA: begin
                        if (take_aad) begin
                            s_r      <= s_next;
                            aad_left <= aad_left - 58'd1;
                        end
                        if (take_pt) pt_r <= pt_in;
                    end
                    CTENC: if (core_done) begin
                        o_cipher_text <= ct_val;
                        o_cp_ready    <= 1'b1;
                        s_r           <= s_next;
                        cb_r          <= {cb_r[127:32], cb_r[31:0] + 32'd1};
                        pt_left       <= pt_left - 58'd1;
                    end
                    LENBLK: s_r <= s_next;
                    DONE: begin
                        o_tag       <= s_r ^ ej0_r;
                        o_tag_ready <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gcm_aes_128.sv
// Directed-vector bench for gcm_aes_128: NIST GCM vectors plus abort, reset and
// spurious-strobe sequences.

module tb_gcm_aes_128;
    logic         clk = 1'b0;
    logic         i_rst_n, i_new_instance, i_pt_instance;
    logic [0:127] i_cipher_key, i_plain_text, i_aad;
    logic [0:95]  i_iv;
    logic [0:63]  i_plain_text_size, i_aad_size;
    logic [0:127] o_cipher_text, o_tag;
    logic         o_tag_ready, o_cp_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [127:0]        key;
        logic [95:0]         iv;
        logic [63:0]         aad_bits;
        logic [63:0]         pt_bits;
        logic [5:0][127:0]   din;
        logic [3:0][127:0]   ct;
        logic [127:0]        tag;
    } vec_t;

    vec_t tbl [3];

    always #5 clk = ~clk;

    gcm_aes_128 dut (
        .clk               (clk),
        .i_rst_n           (i_rst_n),
        .i_new_instance    (i_new_instance),
        .i_pt_instance     (i_pt_instance),
        .i_cipher_key      (i_cipher_key),
        .i_iv              (i_iv),
        .i_plain_text      (i_plain_text),
        .i_aad             (i_aad),
        .i_plain_text_size (i_plain_text_size),
        .i_aad_size        (i_aad_size),
        .o_cipher_text     (o_cipher_text),
        .o_tag             (o_tag),
        .o_tag_ready       (o_tag_ready),
        .o_cp_ready        (o_cp_ready)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input vec_t v);
        i_cipher_key      = v.key;
        i_iv              = v.iv;
        i_aad_size        = v.aad_bits;
        i_plain_text_size = v.pt_bits;
        i_new_instance    = 1'b1;
        step();
        i_new_instance    = 1'b0;
    endtask

    task automatic run_vec(input int idx, input bit noise);
        vec_t v;
        int   na, np, lat;
        bit   bad, got;
        v  = tbl[idx];
        na = int'((v.aad_bits + 64'd127) >> 7);
        np = int'((v.pt_bits + 64'd127) >> 7);
        start_run(v);
        chk($sformatf("v%0d tag_ready_cleared", idx), 128'(o_tag_ready), 128'd0);
        chk($sformatf("v%0d tag_cleared", idx), o_tag, 128'd0);
        if (na + np == 0) begin
            lat = 0;
            for (int c = 1; c <= 40; c++) begin
                step();
                if (o_tag_ready) begin lat = c; break; end
            end
            chk($sformatf("v%0d tag_latency", idx), 128'(lat), 128'd26);
        end else begin
            bad = 1'b0;
            for (int c = 1; c <= 24; c++) begin
                i_pt_instance = noise && (c == 3 || c == 24);
                step();
                if (o_cp_ready || o_tag_ready) bad = 1'b1;
            end
            i_pt_instance = 1'b0;
            chk($sformatf("v%0d quiet_setup", idx), 128'(bad), 128'd0);
            for (int b = 0; b < na; b++) begin
                i_aad = v.din[b];
                i_pt_instance = 1'b1;
                step();
            end
            i_pt_instance = 1'b0;
            for (int p = 0; p < np; p++) begin
                i_plain_text  = v.din[na + p];
                i_pt_instance = 1'b1;
                step();
                lat = 0;
                got = 1'b0;
                for (int c = 1; c <= 40; c++) begin
                    i_pt_instance = noise && (c == 5);
                    step();
                    if (o_cp_ready) begin lat = c; got = 1'b1; break; end
                end
                i_pt_instance = 1'b0;
                chk($sformatf("v%0d ct%0d_latency", idx, p), 128'(lat), 128'd12);
                chk($sformatf("v%0d ct%0d", idx, p), o_cipher_text, v.ct[p]);
                step();
                chk($sformatf("v%0d ct%0d_pulse", idx, p), 128'(o_cp_ready), 128'd0);
            end
            lat = 0;
            for (int c = 1; c <= 20; c++) begin
                if (o_tag_ready) break;
                step();
                if (o_tag_ready) lat = c + 1;
            end
            chk($sformatf("v%0d tag_after_last", idx), 128'(lat), 128'd2);
        end
        chk($sformatf("v%0d tag_ready", idx), 128'(o_tag_ready), 128'd1);
        chk($sformatf("v%0d tag", idx), o_tag, v.tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '0;
        tbl[0].tag = 128'h58e2fccefa7e3061367f1d57a4e7455a;

        tbl[1] = '0;
        tbl[1].pt_bits = 64'd128;
        tbl[1].ct[0]   = 128'h0388dace60b6a392f328c2b971b2fe78;
        tbl[1].tag     = 128'hab6e47d42cec13bdf53a67b21257bddf;

        tbl[2] = '0;
        tbl[2].key      = 128'hfeffe9928665731c6d6a8f9467308308;
        tbl[2].iv       = 96'hcafebabefacedbaddecaf888;
        tbl[2].aad_bits = 64'd160;
        tbl[2].pt_bits  = 64'd480;
        tbl[2].din[0]   = 128'hfeedfacedeadbeeffeedfacedeadbeef;
        tbl[2].din[1]   = 128'habaddad2555555555555555555555555;
        tbl[2].din[2]   = 128'hd9313225f88406e5a55909c5aff5269a;
        tbl[2].din[3]   = 128'h86a7a9531534f7da2e4c303d8a318a72;
        tbl[2].din[4]   = 128'h1c3c0c95956809532fcf0e2449a6b525;
        tbl[2].din[5]   = 128'hb16aedf5aa0de657ba637b39deadbeef;
        tbl[2].ct[0]    = 128'h42831ec2217774244b7221b784d0d49c;
        tbl[2].ct[1]    = 128'he3aa212f2c02a4e035c17e2329aca12e;
        tbl[2].ct[2]    = 128'h21d514b25466931c7d8f6a5aac84aa05;
        tbl[2].ct[3]    = 128'h1ba30b396a0aac973d58e09100000000;
        tbl[2].tag      = 128'h5bc94fbc3221a5db94fae95ae7121a47;

        i_rst_n = 1'b0; i_new_instance = 1'b0; i_pt_instance = 1'b0;
        i_cipher_key = '0; i_iv = '0; i_plain_text = '0; i_aad = '0;
        i_plain_text_size = '0; i_aad_size = '0;
        repeat (3) step();
        chk("reset ct", o_cipher_text, 128'd0);
        chk("reset tag", o_tag, 128'd0);
        chk("reset tag_ready", 128'(o_tag_ready), 128'd0);
        chk("reset cp_ready", 128'(o_cp_ready), 128'd0);
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 3; i++) run_vec(i, 1'b0);

        // Spurious strobes in HGEN, at the last J0ENC edge and inside CTENC.
        run_vec(1, 1'b1);
        chk("hash_key", dut.h_r, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        // Abort the NIST run in the middle of its first plaintext block.
        start_run(tbl[2]);
        repeat (24) step();
        i_pt_instance = 1'b1;
        for (int b = 0; b < 2; b++) begin
            i_aad = tbl[2].din[b];
            step();
        end
        i_plain_text = tbl[2].din[2];
        step();
        i_pt_instance = 1'b0;
        repeat (5) step();
        run_vec(0, 1'b0);

        // Asynchronous reset while a block is being encrypted.
        start_run(tbl[1]);
        repeat (24) step();
        i_plain_text  = '0;
        i_pt_instance = 1'b1;
        step();
        i_pt_instance = 1'b0;
        repeat (4) step();
        chk("pre_reset ct held", o_cipher_text, 128'h0388dace60b6a392f328c2b971b2fe78);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midreset ct", o_cipher_text, 128'd0);
        chk("midreset tag", o_tag, 128'd0);
        chk("midreset tag_ready", 128'(o_tag_ready), 128'd0);
        chk("midreset state", 128'(dut.state_q), 128'd0);
        step();
        step();
        i_rst_n = 1'b1;
        step();
        run_vec(1, 1'b0);
        run_vec(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
